map_ss_seq: RTL and testbench

Save-state sequencer: the initiator side of the mapper save-state register interface. On command it walks the active mapper's snapshot register space and copies each register into a snapshot buffer (save), or copies buffer contents back into the mapper (load). It sits between the system save-state control logic and the mapper selected by map_idx, and drives the same ss address/strobe lines that every mapper decodes.

---
 rtl/map_ss_seq.sv | 155 +++++++++++++++
 tb/tb_map_ss_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/map_ss_seq.sv
// Save-state sequencer: walks the active mapper's snapshot registers and copies them
// to the snapshot buffer (save) or back from it (load), with a map_idx header at buffer[0].
module map_ss_seq #(
    parameter int N_REGS = 32,
    parameter int RD_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] map_idx,
    input  logic       start,
    input  logic       mode,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] ss_addr,
    output logic       ss_oe,
    output logic       ss_we,
    output logic [7:0] ss_din,
    input  logic [7:0] ss_dout,
    output logic [7:0] buf_addr,
    output logic       buf_we,
    output logic       buf_re,
    output logic [7:0] buf_din,
    input  logic [7:0] buf_dout
);

    typedef enum logic [2:0] {IDLE, HDR, ADDR, WAIT, XFER, CHK, DONE} state_t;

    localparam logic [7:0] LAST  = 8'(N_REGS - 1);
    localparam logic [2:0] WLAST = 3'(RD_LAT - 1);

    state_t     state;
    logic       ld;
    logic       hdr;
    logic [7:0] idx;
    logic [7:0] k;
    logic [2:0] wcnt;

    // Every output is set on the edge entering the state it belongs to, so
    // read data is sampled in the last WAIT cycle, RD_LAT cycles after the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ld       <= 1'b0;
            hdr      <= 1'b0;
            idx      <= '0;
            k        <= '0;
            wcnt     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            ss_addr  <= '0;
            ss_oe    <= 1'b0;
            ss_we    <= 1'b0;
            ss_din   <= '0;
            buf_addr <= '0;
            buf_we   <= 1'b0;
            buf_re   <= 1'b0;
            buf_din  <= '0;
        end else begin
            ss_oe  <= 1'b0;
            ss_we  <= 1'b0;
            buf_we <= 1'b0;
            buf_re <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            if (state != IDLE && abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        ld       <= mode;
                        idx      <= map_idx;
                        k        <= '0;
                        busy     <= 1'b1;
                        buf_addr <= '0;
                        if (mode) begin
                            hdr    <= 1'b1;
                            buf_re <= 1'b1;
                            state  <= ADDR;
                        end else begin
                            hdr     <= 1'b0;
                            buf_we  <= 1'b1;
                            buf_din <= map_idx;
                            state   <= HDR;
                        end
                    end
                    HDR: begin
                        ss_addr <= k;
                        ss_oe   <= 1'b1;
                        state   <= ADDR;
                    end
                    ADDR: begin
                        wcnt  <= '0;
                        state <= WAIT;
                    end
                    WAIT: if (wcnt == WLAST) begin
                        if (ld && hdr) begin
                            // err doubles as the header verdict inside CHK
                            err   <= (buf_dout != idx);
                            hdr   <= 1'b0;
                            state <= CHK;
                        end else if (ld) begin
                            ss_we   <= 1'b1;
                            ss_addr <= k;
                            ss_din  <= buf_dout;
                            state   <= XFER;
                        end else begin
                            buf_we   <= 1'b1;
                            buf_addr <= 8'(k + 8'd1);
                            buf_din  <= ss_dout;
                            state    <= XFER;
                        end
                    end else begin
                        wcnt <= wcnt + 3'd1;
                    end
                    XFER: if (k == LAST) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        k     <= k + 8'd1;
                        state <= ADDR;
                        if (ld) begin
                            buf_addr <= 8'(k + 8'd2);
                            buf_re   <= 1'b1;
                        end else begin
                            ss_addr <= k + 8'd1;
                            ss_oe   <= 1'b1;
                        end
                    end
                    CHK: if (err) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        k        <= '0;
                        buf_addr <= 8'd1;
                        buf_re   <= 1'b1;
                        state    <= ADDR;
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_map_ss_seq.sv
// Directed bench for map_ss_seq: mapper and buffer models with 2-cycle read latency,
// save/load/header-mismatch/abort/restart/reset scenarios.
module tb_map_ss_seq;

    localparam int N  = 4;
    localparam int RL = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] map_idx = '0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       abort = 1'b0;
    logic       busy, done, err, ss_oe, ss_we, buf_we, buf_re;
    logic [7:0] ss_addr, ss_din, ss_dout, buf_addr, buf_din, buf_dout;

    map_ss_seq #(.N_REGS(N), .RD_LAT(RL)) dut (
        .clk(clk), .rst_n(rst_n), .map_idx(map_idx), .start(start), .mode(mode),
        .abort(abort), .busy(busy), .done(done), .err(err),
        .ss_addr(ss_addr), .ss_oe(ss_oe), .ss_we(ss_we), .ss_din(ss_din),
        .ss_dout(ss_dout), .buf_addr(buf_addr), .buf_we(buf_we), .buf_re(buf_re),
        .buf_din(buf_din), .buf_dout(buf_dout)
    );

    always #5 clk = ~clk;

    logic [7:0] mreg [0:7];
    logic [7:0] bmem [0:7];
    logic [7:0] sp1 = 8'hEE, sp2 = 8'hEE, bp1 = 8'hEE, bp2 = 8'hEE;

    // Read data is only meaningful RL cycles after a strobe; anything else reads EE.
    always @(posedge clk) begin
        sp1 <= ss_oe  ? mreg[ss_addr[2:0]]  : 8'hEE;
        sp2 <= sp1;
        bp1 <= buf_re ? bmem[buf_addr[2:0]] : 8'hEE;
        bp2 <= bp1;
    end
    assign ss_dout  = sp2;
    assign buf_dout = bp2;

    int n_tests = 0, n_fail = 0;
    int cyc, ndone, nerr, done_at, err_at, nw;
    logic [7:0] wa [0:15];
    logic [7:0] wd [0:15];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle and log what the registered outputs do in that cycle.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (buf_we) bmem[buf_addr[2:0]] = buf_din;
        if (ss_we && nw < 16) begin
            wa[nw] = ss_addr;
            wd[nw] = ss_din;
            nw++;
        end
        if (done) begin ndone++; done_at = cyc; end
        if (err)  begin nerr++;  err_at  = cyc; end
    endtask

    task automatic do_start(input logic m, input logic [7:0] idx);
        ndone = 0; nerr = 0; nw = 0; done_at = -1; err_at = -1; cyc = -1;
        map_idx = idx; mode = m; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_idle();
        int n = 0;
        while (busy && n < 300) begin
            step();
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            mreg[i] = 8'hA0 + 8'(i);
            bmem[i] = 8'h55;
        end
        #1;
        chk("rst_flags", {25'd0, busy, done, err, ss_oe, ss_we, buf_we, buf_re}, 32'd0);
        chk("rst_addr", {16'd0, ss_addr, buf_addr}, 32'd0);
        chk("rst_data", {16'd0, ss_din, buf_din}, 32'd0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // save
        do_start(1'b0, 8'h04);
        chk("save_busy_hdr", {31'd0, busy}, 32'd1);
        run_idle();
        chk("save_hdr", {24'd0, bmem[0]}, 32'h04);
        for (int i = 1; i <= N; i++) chk($sformatf("save_buf%0d", i), {24'd0, bmem[i]}, 32'hA0 + i - 1);
        chk("save_ndone", ndone, 1);
        chk("save_done_at", done_at, 17);
        chk("save_idle_at", cyc, 18);
        chk("save_no_sswe", nw, 0);

        // load, header matches
        bmem[0] = 8'h04; bmem[1] = 8'h11; bmem[2] = 8'h22; bmem[3] = 8'h33; bmem[4] = 8'h44;
        do_start(1'b1, 8'h04);
        run_idle();
        chk("load_nw", nw, 4);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("load_addr%0d", i), {24'd0, wa[i]}, i);
            chk($sformatf("load_din%0d", i), {24'd0, wd[i]}, 32'h11 * (i + 1));
        end
        chk("load_nerr", nerr, 0);
        chk("load_done_at", done_at, 20);

        // load, header mismatch
        bmem[0] = 8'h05;
        do_start(1'b1, 8'h04);
        run_idle();
        chk("hdr_nerr", nerr, 1);
        chk("hdr_err_at", err_at, 3);
        chk("hdr_idle_at", cyc, 4);
        chk("hdr_nw", nw, 0);
        chk("hdr_ndone", ndone, 0);

        // abort during WAIT of k=2
        for (int i = 0; i < 8; i++) bmem[i] = 8'h55;
        do_start(1'b0, 8'h04);
        repeat (10) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_strobes", {28'd0, ss_oe, ss_we, buf_we, buf_re}, 32'd0);
        repeat (3) step();
        chk("abort_ndone", ndone, 0);
        chk("abort_buf2", {24'd0, bmem[2]}, 32'hA1);
        chk("abort_buf3", {24'd0, bmem[3]}, 32'h55);
        chk("abort_buf4", {24'd0, bmem[4]}, 32'h55);
        do_start(1'b0, 8'h07);
        run_idle();
        chk("restart_ndone", ndone, 1);
        chk("restart_hdr", {24'd0, bmem[0]}, 32'h07);
        chk("restart_buf3", {24'd0, bmem[3]}, 32'hA2);

        // start while busy plus map_idx change
        do_start(1'b0, 8'h04);
        repeat (5) step();
        start = 1'b1; mode = 1'b1; map_idx = 8'h09;
        step();
        start = 1'b0;
        run_idle();
        chk("busy_start_done_at", done_at, 17);
        chk("busy_start_ndone", ndone, 1);
        chk("busy_start_hdr", {24'd0, bmem[0]}, 32'h04);
        chk("busy_start_nw", nw, 0);

        // async reset mid-load
        map_idx = 8'h04;
        do_start(1'b1, 8'h04);
        repeat (6) step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_flags", {25'd0, busy, done, err, ss_oe, ss_we, buf_we, buf_re}, 32'd0);
        chk("arst_addr", {16'd0, ss_addr, buf_addr}, 32'd0);
        chk("arst_data", {16'd0, ss_din, buf_din}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_idle", {31'd0, busy}, 32'd0);
        do_start(1'b0, 8'h04);
        run_idle();
        chk("arst_save_done_at", done_at, 17);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
